// File: rtl/tube_pkg.sv
// Shared constants and types for the eight-digit 7-segment tube driver.
// Holds the digit count, the all-off level, the hex segment table and the digit index type.
package tube_pkg;

   localparam int DIGITS = 8;

   localparam logic [7:0] SEG_OFF = 8'h00;

   // Segment patterns {dp,g,f,e,d,c,b,a} for hex digits 0..F; dp is always 0.
   localparam logic [7:0] SEG_LUT [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F,
      8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C,
      8'h39, 8'h5E, 8'h79, 8'h71
   };

   typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/tube_hex2seg.sv
// Combinational nibble to 7-segment decode using the shared table.
// Ports: nibble (4-bit hex value in), seg (8-bit {dp,g,f,e,d,c,b,a} out, active-high).
module tube_hex2seg
   import tube_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] seg
);

   assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/tube_display.sv
// Eight-digit multiplexed 7-segment driver fed by the tube IO write path.
// Ports: clk, rst_n (synchronous, active-high), TubeCtrl_i/iow_i/iowrite_data_i (write),
//   seg_en_o (one-hot digit enable), seg_out_o ({dp,g..a}), disp_data_o (display readback).
// Optional macro TUBE_LEAD_ZERO_BLANK_EN blanks leading-zero digits 1..7.
module tube_display
   import tube_pkg::*;
#(
   parameter int   SCAN_DIV = 100000,
   parameter logic SEG_POL  = 1'b1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        TubeCtrl_i,
   input  logic        iow_i,
   input  logic [31:0] iowrite_data_i,
   output logic [7:0]  seg_en_o,
   output logic [7:0]  seg_out_o,
   output logic [31:0] disp_data_o
);

   localparam int CW = $clog2(SCAN_DIV);

   // Level driven on the pins when nothing is lit, after polarity.
   localparam logic [7:0] OFF_LVL = SEG_POL ? SEG_OFF : ~SEG_OFF;

   logic [31:0]   disp;
   logic [CW-1:0] div_cnt;
   digit_idx_t    idx;
   logic          tick;
   logic [3:0]    nib;
   logic [7:0]    seg_raw;
   logic          blank;
   logic [7:0]    en_nxt;
   logic [7:0]    seg_nxt;

   assign tick        = (div_cnt == CW'(SCAN_DIV - 1));
   assign nib         = disp[{idx, 2'b00} +: 4];
   assign disp_data_o = disp;

   tube_hex2seg u_hex2seg (
      .nibble (nib),
      .seg    (seg_raw)
   );

   always_comb begin
      blank = 1'b0;
`ifdef TUBE_LEAD_ZERO_BLANK_EN
      // Digit i is a leading zero when every nibble from i upward is zero.
      blank = (idx != '0) && ((disp >> {idx, 2'b00}) == 32'd0);
`endif
      en_nxt  = blank ? SEG_OFF : (8'b1 << idx);
      seg_nxt = blank ? SEG_OFF : seg_raw;
      if (!SEG_POL) begin
         en_nxt  = ~en_nxt;
         seg_nxt = ~seg_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         disp      <= 32'd0;
         div_cnt   <= '0;
         idx       <= '0;
         seg_en_o  <= OFF_LVL;
         seg_out_o <= OFF_LVL;
      end else begin
         if (TubeCtrl_i && iow_i) begin
            disp <= iowrite_data_i;
         end
         if (tick) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end
         seg_en_o  <= en_nxt;
         seg_out_o <= seg_nxt;
      end
   end

endmodule
